// File: rtl/regfile_mp_sb.sv
// rtl/regfile_mp_sb.sv - multi-port integer register file with per-register scoreboard
// Purpose: NRD zero-latency read ports with same-cycle write bypass, NWR
// write-back ports (highest index wins on collision), and a pending-producer
// scoreboard so decode can stall on RAW (rd_ready) and WAW (iss_ready).
// Ports:
//   clk, rst_n                   clock, synchronous active-low reset
//   rd_addr / rd_data / rd_ready read ports, port i at slice i
//   iss_valid / iss_rd / iss_ready issue handshake; accepted issue sets pend
//   wr_en / wr_addr / wr_data    write-back ports; a write clears pend
//   pend                         registered scoreboard vector
module regfile_mp_sb #(
  parameter int XLEN      = 32,
  parameter int REG_NUM   = 32,
  parameter int ADDR_SIZE = 5,
  parameter int NRD       = 2,
  parameter int NWR       = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NRD*ADDR_SIZE-1:0] rd_addr,
  output logic [NRD*XLEN-1:0]      rd_data,
  output logic [NRD-1:0]           rd_ready,
  input  logic                     iss_valid,
  input  logic [ADDR_SIZE-1:0]     iss_rd,
  output logic                     iss_ready,
  input  logic [NWR-1:0]           wr_en,
  input  logic [NWR*ADDR_SIZE-1:0] wr_addr,
  input  logic [NWR*XLEN-1:0]      wr_data,
  output logic [REG_NUM-1:0]       pend
);

  logic [XLEN-1:0]    regs_q [REG_NUM];
  logic [XLEN-1:0]    regs_d [REG_NUM];
  logic [REG_NUM-1:0] pend_q;
  logic [REG_NUM-1:0] pend_d;

  // Per-register view of this cycle's write-backs: wr_hit[r] says some port
  // writes r, wr_val[r] carries the value of the highest-index such port.
  logic [REG_NUM-1:0] wr_hit;
  logic [XLEN-1:0]    wr_val [REG_NUM];

  function automatic logic in_range(input logic [ADDR_SIZE-1:0] a);
    return int'(a) < REG_NUM;
  endfunction

  always_comb begin
    wr_hit = '0;
    for (int r = 0; r < REG_NUM; r++) wr_val[r] = '0;
    // Ascending port order lets the highest-index port overwrite the others.
    for (int j = 0; j < NWR; j++) begin
      for (int r = 1; r < REG_NUM; r++) begin
        if (wr_en[j] && wr_addr[j*ADDR_SIZE +: ADDR_SIZE] == ADDR_SIZE'(r)) begin
          wr_hit[r] = 1'b1;
          wr_val[r] = wr_data[j*XLEN +: XLEN];
        end
      end
    end
  end

  // Reads: r0 and out-of-range addresses return 0 and are always ready; a
  // same-cycle write supplies the operand, so it is ready even if pending.
  always_comb begin
    rd_data  = '0;
    rd_ready = '1;
    for (int i = 0; i < NRD; i++) begin
      if (rd_addr[i*ADDR_SIZE +: ADDR_SIZE] != '0 && in_range(rd_addr[i*ADDR_SIZE +: ADDR_SIZE])) begin
        if (wr_hit[rd_addr[i*ADDR_SIZE +: ADDR_SIZE]]) begin
          rd_data[i*XLEN +: XLEN] = wr_val[rd_addr[i*ADDR_SIZE +: ADDR_SIZE]];
        end else begin
          rd_data[i*XLEN +: XLEN] = regs_q[rd_addr[i*ADDR_SIZE +: ADDR_SIZE]];
          rd_ready[i]             = !pend_q[rd_addr[i*ADDR_SIZE +: ADDR_SIZE]];
        end
      end
    end
  end

  // A completing producer frees the slot in the same cycle, so a new issue to
  // that register may be accepted alongside its write-back.
  assign iss_ready = (iss_rd == '0) || !in_range(iss_rd) || !pend_q[iss_rd] || wr_hit[iss_rd];

  always_comb begin
    pend_d = pend_q;
    for (int r = 0; r < REG_NUM; r++) regs_d[r] = regs_q[r];
    for (int r = 1; r < REG_NUM; r++) begin
      if (wr_hit[r]) regs_d[r] = wr_val[r];
      // Set beats clear: the newly issued producer supersedes the completing one.
      if (iss_valid && iss_ready && iss_rd == ADDR_SIZE'(r)) begin
        pend_d[r] = 1'b1;
      end else if (wr_hit[r]) begin
        pend_d[r] = 1'b0;
      end
    end
    pend_d[0] = 1'b0;
    regs_d[0] = '0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pend_q <= '0;
      for (int r = 0; r < REG_NUM; r++) regs_q[r] <= '0;
    end else begin
      pend_q <= pend_d;
      for (int r = 0; r < REG_NUM; r++) regs_q[r] <= regs_d[r];
    end
  end

  assign pend = pend_q;

endmodule

// File: tb/tb_regfile_mp_sb.sv
// tb/tb_regfile_mp_sb.sv - self-checking bench for regfile_mp_sb
module tb_regfile_mp_sb;
  localparam int XLEN = 32;
  localparam int REG_NUM = 32;
  localparam int AS = 5;
  localparam int NRD = 2;
  localparam int NWR = 2;

  logic                clk = 1'b0;
  logic                rst_n;
  logic [NRD*AS-1:0]   rd_addr;
  logic [NRD*XLEN-1:0] rd_data;
  logic [NRD-1:0]      rd_ready;
  logic                iss_valid;
  logic [AS-1:0]       iss_rd;
  logic                iss_ready;
  logic [NWR-1:0]      wr_en;
  logic [NWR*AS-1:0]   wr_addr;
  logic [NWR*XLEN-1:0] wr_data;
  logic [REG_NUM-1:0]  pend;

  regfile_mp_sb #(.XLEN(XLEN), .REG_NUM(REG_NUM), .ADDR_SIZE(AS), .NRD(NRD), .NWR(NWR)) dut (
    .clk(clk), .rst_n(rst_n), .rd_addr(rd_addr), .rd_data(rd_data), .rd_ready(rd_ready),
    .iss_valid(iss_valid), .iss_rd(iss_rd), .iss_ready(iss_ready),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .pend(pend)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail = 0;
  logic [31:0] exp_q[$];
  logic [31:0] e;

  task automatic drive_idle();
    rst_n = 1'b1; rd_addr = '0; iss_valid = 1'b0; iss_rd = '0;
    wr_en = '0; wr_addr = '0; wr_data = '0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b0; wr_en = 2'b11; wr_addr = {5'd5, 5'd5}; wr_data = {32'hDEAD, 32'hDEAD};
    iss_valid = 1'b1; iss_rd = 5'd5;
    @(negedge clk);
    @(negedge clk);
    drive_idle();
    for (int r = 0; r < REG_NUM; r += 2) begin
      rd_addr = {5'(r + 1), 5'(r)};
      exp_q.push_back(32'h0); exp_q.push_back(32'h0);
      #1;
      e = exp_q.pop_front(); n_tests++;
      if (rd_data[31:0] !== e) begin n_fail++; $display("FAIL reset_rd r%0d got %h exp %h", r, rd_data[31:0], e); end
      e = exp_q.pop_front(); n_tests++;
      if (rd_data[63:32] !== e) begin n_fail++; $display("FAIL reset_rd r%0d got %h exp %h", r + 1, rd_data[63:32], e); end
    end
    exp_q.push_back(32'h0);
    e = exp_q.pop_front(); n_tests++;
    if (pend !== e) begin n_fail++; $display("FAIL reset_pend got %h exp %h", pend, e); end
  endtask

  task automatic test_bypass();
    @(negedge clk);
    drive_idle();
    wr_en = 2'b11; wr_addr = {5'd7, 5'd7}; wr_data = {32'h22, 32'h11}; rd_addr = {5'd0, 5'd7};
    exp_q.push_back(32'h22); exp_q.push_back(32'h0);
    #2;
    e = exp_q.pop_front(); n_tests++;
    if (rd_data[31:0] !== e) begin n_fail++; $display("FAIL bypass_prio got %h exp %h", rd_data[31:0], e); end
    e = exp_q.pop_front(); n_tests++;
    if (rd_data[63:32] !== e) begin n_fail++; $display("FAIL bypass_r0 got %h exp %h", rd_data[63:32], e); end
    @(negedge clk);
    drive_idle(); rd_addr = {5'd0, 5'd7};
    exp_q.push_back(32'h22);
    #2;
    e = exp_q.pop_front(); n_tests++;
    if (rd_data[31:0] !== e) begin n_fail++; $display("FAIL array_r7 got %h exp %h", rd_data[31:0], e); end
    @(negedge clk);
    drive_idle(); wr_en = 2'b01; wr_data = {32'h0, 32'hFF};
    exp_q.push_back(32'h0);
    #2;
    e = exp_q.pop_front(); n_tests++;
    if (rd_data[31:0] !== e) begin n_fail++; $display("FAIL r0_bypass got %h exp %h", rd_data[31:0], e); end
    @(negedge clk);
    drive_idle();
    exp_q.push_back(32'h0); exp_q.push_back(32'h0);
    #2;
    e = exp_q.pop_front(); n_tests++;
    if (rd_data[31:0] !== e) begin n_fail++; $display("FAIL r0_array got %h exp %h", rd_data[31:0], e); end
    e = exp_q.pop_front(); n_tests++;
    if (pend !== e) begin n_fail++; $display("FAIL bypass_pend got %h exp %h", pend, e); end
  endtask

  task automatic test_raw();
    @(negedge clk);
    drive_idle(); iss_valid = 1'b1; iss_rd = 5'd3;
    exp_q.push_back(32'h1);
    #2;
    e = exp_q.pop_front(); n_tests++;
    if ({31'b0, iss_ready} !== e) begin n_fail++; $display("FAIL raw_issue got %0d exp %0d", iss_ready, e); end
    for (int c = 1; c < 4; c++) begin
      @(negedge clk);
      drive_idle(); rd_addr = {5'd0, 5'd3};
      exp_q.push_back(32'h8); exp_q.push_back(32'h0);
      #2;
      e = exp_q.pop_front(); n_tests++;
      if (pend !== e) begin n_fail++; $display("FAIL raw_pend c%0d got %h exp %h", c, pend, e); end
      e = exp_q.pop_front(); n_tests++;
      if ({31'b0, rd_ready[0]} !== e) begin n_fail++; $display("FAIL raw_stall c%0d got %0d exp %0d", c, rd_ready[0], e); end
    end
    @(negedge clk);
    drive_idle(); rd_addr = {5'd0, 5'd3}; wr_en = 2'b01; wr_addr = {5'd0, 5'd3}; wr_data = {32'h0, 32'h55};
    exp_q.push_back(32'h1); exp_q.push_back(32'h55);
    #2;
    e = exp_q.pop_front(); n_tests++;
    if ({31'b0, rd_ready[0]} !== e) begin n_fail++; $display("FAIL raw_ready_wb got %0d exp %0d", rd_ready[0], e); end
    e = exp_q.pop_front(); n_tests++;
    if (rd_data[31:0] !== e) begin n_fail++; $display("FAIL raw_data_wb got %h exp %h", rd_data[31:0], e); end
    @(negedge clk);
    drive_idle(); rd_addr = {5'd0, 5'd3};
    exp_q.push_back(32'h0); exp_q.push_back(32'h55);
    #2;
    e = exp_q.pop_front(); n_tests++;
    if (pend !== e) begin n_fail++; $display("FAIL raw_pend_clr got %h exp %h", pend, e); end
    e = exp_q.pop_front(); n_tests++;
    if (rd_data[31:0] !== e) begin n_fail++; $display("FAIL raw_data_arr got %h exp %h", rd_data[31:0], e); end
  endtask

  task automatic test_waw();
    @(negedge clk);
    drive_idle(); iss_valid = 1'b1; iss_rd = 5'd9;
    @(negedge clk);
    drive_idle(); iss_valid = 1'b1; iss_rd = 5'd9;
    exp_q.push_back(32'h0); exp_q.push_back(32'h200);
    #2;
    e = exp_q.pop_front(); n_tests++;
    if ({31'b0, iss_ready} !== e) begin n_fail++; $display("FAIL waw_block got %0d exp %0d", iss_ready, e); end
    e = exp_q.pop_front(); n_tests++;
    if (pend !== e) begin n_fail++; $display("FAIL waw_pend got %h exp %h", pend, e); end
    @(negedge clk);
    exp_q.push_back(32'h200);
    #2;
    e = exp_q.pop_front(); n_tests++;
    if (pend !== e) begin n_fail++; $display("FAIL waw_unchanged got %h exp %h", pend, e); end
    wr_en = 2'b10; wr_addr = {5'd9, 5'd0}; wr_data = {32'h99, 32'h0};
    exp_q.push_back(32'h1);
    #1;
    e = exp_q.pop_front(); n_tests++;
    if ({31'b0, iss_ready} !== e) begin n_fail++; $display("FAIL waw_wb_accept got %0d exp %0d", iss_ready, e); end
    @(negedge clk);
    drive_idle(); wr_en = 2'b01; wr_addr = {5'd0, 5'd9}; wr_data = {32'h0, 32'h98};
    exp_q.push_back(32'h200);
    #2;
    e = exp_q.pop_front(); n_tests++;
    if (pend !== e) begin n_fail++; $display("FAIL waw_set_wins got %h exp %h", pend, e); end
    @(negedge clk);
    drive_idle();
    exp_q.push_back(32'h0);
    #2;
    e = exp_q.pop_front(); n_tests++;
    if (pend !== e) begin n_fail++; $display("FAIL waw_final got %h exp %h", pend, e); end
  endtask

  task automatic test_multi();
    @(negedge clk);
    drive_idle(); iss_valid = 1'b1; iss_rd = 5'd1;
    @(negedge clk);
    drive_idle(); iss_valid = 1'b1; iss_rd = 5'd2;
    @(negedge clk);
    drive_idle();
    wr_en = 2'b11; wr_addr = {5'd2, 5'd1}; wr_data = {32'hB, 32'hA};
    iss_valid = 1'b1; iss_rd = 5'd4; rd_addr = {5'd2, 5'd1};
    exp_q.push_back(32'h6); exp_q.push_back(32'hA); exp_q.push_back(32'hB);
    exp_q.push_back(32'h3); exp_q.push_back(32'h1);
    #2;
    e = exp_q.pop_front(); n_tests++;
    if (pend !== e) begin n_fail++; $display("FAIL multi_pre_pend got %h exp %h", pend, e); end
    e = exp_q.pop_front(); n_tests++;
    if (rd_data[31:0] !== e) begin n_fail++; $display("FAIL multi_rd0 got %h exp %h", rd_data[31:0], e); end
    e = exp_q.pop_front(); n_tests++;
    if (rd_data[63:32] !== e) begin n_fail++; $display("FAIL multi_rd1 got %h exp %h", rd_data[63:32], e); end
    e = exp_q.pop_front(); n_tests++;
    if ({30'b0, rd_ready} !== e) begin n_fail++; $display("FAIL multi_ready got %b exp %b", rd_ready, e[1:0]); end
    e = exp_q.pop_front(); n_tests++;
    if ({31'b0, iss_ready} !== e) begin n_fail++; $display("FAIL multi_iss got %0d exp %0d", iss_ready, e); end
    @(negedge clk);
    drive_idle(); wr_en = 2'b10; wr_addr = {5'd4, 5'd0}; wr_data = {32'h44, 32'h0};
    exp_q.push_back(32'h10);
    #2;
    e = exp_q.pop_front(); n_tests++;
    if (pend !== e) begin n_fail++; $display("FAIL multi_pend got %h exp %h", pend, e); end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    drive_idle(); iss_valid = 1'b1; iss_rd = 5'd6;
    @(negedge clk);
    drive_idle(); rst_n = 1'b0;
    @(negedge clk);
    drive_idle(); wr_en = 2'b01; wr_addr = {5'd0, 5'd6}; wr_data = {32'h0, 32'h77};
    exp_q.push_back(32'h0);
    #2;
    e = exp_q.pop_front(); n_tests++;
    if (pend !== e) begin n_fail++; $display("FAIL rstmid_pend got %h exp %h", pend, e); end
    @(negedge clk);
    drive_idle(); rd_addr = {5'd4, 5'd6};
    exp_q.push_back(32'h0); exp_q.push_back(32'h77); exp_q.push_back(32'h0);
    #2;
    e = exp_q.pop_front(); n_tests++;
    if (pend !== e) begin n_fail++; $display("FAIL rstmid_pend_wb got %h exp %h", pend, e); end
    e = exp_q.pop_front(); n_tests++;
    if (rd_data[31:0] !== e) begin n_fail++; $display("FAIL rstmid_r6 got %h exp %h", rd_data[31:0], e); end
    e = exp_q.pop_front(); n_tests++;
    if (rd_data[63:32] !== e) begin n_fail++; $display("FAIL rstmid_r4_cleared got %h exp %h", rd_data[63:32], e); end
  endtask

  task automatic test_random();
    logic [31:0] m_regs [REG_NUM];
    logic [31:0] m_pend;
    logic [4:0]  ra [NRD];
    logic [4:0]  wa [NWR];
    logic [31:0] wd [NWR];
    logic [31:0] v;
    logic [1:0]  rdy;
    logic        hit, iexp, clr;
    @(negedge clk);
    drive_idle(); rst_n = 1'b0;
    for (int r = 0; r < REG_NUM; r++) m_regs[r] = '0;
    m_pend = '0;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      drive_idle();
      exp_q.push_back(m_pend);
      e = exp_q.pop_front(); n_tests++;
      if (pend !== e) begin n_fail++; $display("FAIL rnd_pend c%0d got %h exp %h", c, pend, e); end
      for (int j = 0; j < NWR; j++) begin
        wa[j] = 5'($urandom_range(0, 7)); wd[j] = $urandom;
        wr_addr[j*AS +: AS] = wa[j]; wr_data[j*XLEN +: XLEN] = wd[j];
      end
      wr_en = 2'($urandom_range(0, 3));
      for (int i = 0; i < NRD; i++) begin
        ra[i] = 5'($urandom_range(0, 7)); rd_addr[i*AS +: AS] = ra[i];
      end
      iss_valid = 1'($urandom_range(0, 1)); iss_rd = 5'($urandom_range(0, 7));
      for (int i = 0; i < NRD; i++) begin
        v = '0; hit = 1'b0;
        if (ra[i] != 0) begin
          v = m_regs[ra[i]];
          for (int j = 0; j < NWR; j++) if (wr_en[j] && wa[j] == ra[i]) begin v = wd[j]; hit = 1'b1; end
        end
        rdy[i] = (ra[i] == 0) || !m_pend[ra[i]] || hit;
        exp_q.push_back(v);
      end
      clr = 1'b0;
      for (int j = 0; j < NWR; j++) if (wr_en[j] && wa[j] == iss_rd) clr = 1'b1;
      iexp = (iss_rd == 0) || !m_pend[iss_rd] || clr;
      exp_q.push_back({30'b0, rdy});
      exp_q.push_back({31'b0, iexp});
      #2;
      e = exp_q.pop_front(); n_tests++;
      if (rd_data[31:0] !== e) begin n_fail++; $display("FAIL rnd_rd0 c%0d got %h exp %h", c, rd_data[31:0], e); end
      e = exp_q.pop_front(); n_tests++;
      if (rd_data[63:32] !== e) begin n_fail++; $display("FAIL rnd_rd1 c%0d got %h exp %h", c, rd_data[63:32], e); end
      e = exp_q.pop_front(); n_tests++;
      if ({30'b0, rd_ready} !== e) begin n_fail++; $display("FAIL rnd_ready c%0d got %b exp %b", c, rd_ready, e[1:0]); end
      e = exp_q.pop_front(); n_tests++;
      if ({31'b0, iss_ready} !== e) begin n_fail++; $display("FAIL rnd_iss c%0d got %0d exp %0d", c, iss_ready, e); end
      for (int r = 1; r < REG_NUM; r++) begin
        clr = 1'b0;
        for (int j = 0; j < NWR; j++) if (wr_en[j] && wa[j] == 5'(r)) clr = 1'b1;
        if (iss_valid && iexp && iss_rd == 5'(r)) m_pend[r] = 1'b1;
        else if (clr) m_pend[r] = 1'b0;
      end
      for (int j = 0; j < NWR; j++) if (wr_en[j] && wa[j] != 0) m_regs[wa[j]] = wd[j];
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout got running exp finished");
    $fatal(1, "timeout");
  end

  initial begin
    drive_idle();
    test_reset();
    test_bypass();
    test_raw();
    test_waw();
    test_multi();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
